tx_ffe_bdrate: RTL and testbench

Transmit-side baud-rate digital feed-forward equalizer (FFE) for the time-interleaved serial link. It is the transmitter counterpart of the receiver DFE adaptation path. It takes Nti bits per parallel clock and emits Nti signed DAC codes, each a weighted sum of the current bit and the previous Ntap-1 bits. Tap weights arrive from the back-channel/config side through a shadow bank with a request/acknowledge handshake. They are applied atomically through a checked commit.

---
 rtl/tx_ffe_bdrate.sv | 194 +++++++++++++++++++
 tb/tb_tx_ffe_bdrate.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ffe_bdrate.sv
// tx_ffe_bdrate: baud-rate transmit FFE with shadow/active tap banks,
// a request/ack write port and a checked, word-atomic commit.
module tx_ffe_bdrate #(
   parameter int Nti      = 4,
   parameter int Ntap     = 2,
   parameter int Ncoef    = 6,
   parameter int Ncode    = 8,
   parameter int MAIN_RST = 31
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [Nti-1:0]          din,
   output logic signed [Ncode-1:0] dout [Nti],
   input  logic                    coef_req,
   input  logic [$clog2(Ntap):0]   coef_idx,
   input  logic signed [Ncoef-1:0] coef_val,
   output logic                    coef_ack,
   input  logic                    coef_commit,
   output logic                    commit_done,
   output logic                    commit_err
);

   localparam int IW  = $clog2(Ntap) + 1;
   localparam int HW  = (Ntap > 1) ? Ntap - 1 : 1;
   localparam int EW  = Nti + HW;
   localparam int AW  = Ncoef + $clog2(Ntap) + 1;
   localparam int CW  = ((AW > Ncode) ? AW : Ncode) + 1;
   localparam int LIM = 2 ** (Ncode - 1) - 1;

   localparam logic signed [CW-1:0] LIM_P = CW'(LIM);
   localparam logic signed [CW-1:0] LIM_N = -LIM_P;
   localparam logic [CW-1:0]        LIM_U = CW'(LIM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_WAITLOW,
      S_CHECK
   } state_e;

   state_e state_q, state_d;

   logic pend_q, pend_d;
   logic done_q, done_d;
   logic err_q, err_d;
   logic shd_we, act_we;

   logic signed [Ncoef-1:0] c_act_q [Ntap];
   logic signed [Ncoef-1:0] c_shd_q [Ntap];

   logic [HW-1:0]           hist_q, hist_d;
   logic [EW-1:0]           ext;
   logic signed [Ncode-1:0] dout_q [Nti];
   logic signed [Ncode-1:0] dout_d [Nti];

   logic [AW-1:0] sum;
   logic          sum_ok;

   // Bits in time order: oldest history bit at ext[0], din[Nti-1] on top.
   assign ext    = {din, hist_q};
   assign hist_d = ext[EW-1 -: HW];

   always_comb begin
      logic signed [AW-1:0] acc;
      logic signed [AW-1:0] cx;
      logic signed [CW-1:0] accx;
      acc  = '0;
      cx   = '0;
      accx = '0;
      for (int j = 0; j < Nti; j++) begin
         acc = '0;
         for (int k = 0; k < Ntap; k++) begin
            cx = AW'(c_act_q[k]);
            if (ext[j - k + HW])
               acc = acc + cx;
            else
               acc = acc - cx;
         end
         accx = CW'(acc);
         if (accx > LIM_P)
            dout_d[j] = Ncode'(LIM_P);
         else if (accx < LIM_N)
            dout_d[j] = Ncode'(LIM_N);
         else
            dout_d[j] = accx[Ncode-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         for (int j = 0; j < Nti; j++)
            dout_q[j] <= '0;
      end else begin
         hist_q <= hist_d;
         for (int j = 0; j < Nti; j++)
            dout_q[j] <= dout_d[j];
      end
   end

   always_comb begin
      for (int j = 0; j < Nti; j++)
         dout[j] = dout_q[j];
   end

   // L1 norm of the shadow bank bounds the worst-case output magnitude.
   always_comb begin
      logic [Ncoef-1:0] mag;
      mag = '0;
      sum = '0;
      for (int k = 0; k < Ntap; k++) begin
         if (c_shd_q[k][Ncoef-1])
            mag = Ncoef'(-c_shd_q[k]);
         else
            mag = c_shd_q[k];
         sum = sum + AW'(mag);
      end
   end

   assign sum_ok = (CW'(sum) <= LIM_U);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q | coef_commit;
      done_d  = 1'b0;
      err_d   = 1'b0;
      shd_we  = 1'b0;
      act_we  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pend_q || coef_commit) begin
               state_d = S_CHECK;
               pend_d  = 1'b0;
            end else if (coef_req) begin
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            shd_we  = 1'b1;
            state_d = S_WAITLOW;
         end
         S_WAITLOW: begin
            if (!coef_req)
               state_d = S_IDLE;
         end
         S_CHECK: begin
            if (sum_ok) begin
               act_we = 1'b1;
               done_d = 1'b1;
            end else begin
               err_d  = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Out-of-range indices match no tap, so the write is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < Ntap; k++) begin
            c_shd_q[k] <= (k == 0) ? Ncoef'(MAIN_RST) : '0;
            c_act_q[k] <= (k == 0) ? Ncoef'(MAIN_RST) : '0;
         end
      end else begin
         for (int k = 0; k < Ntap; k++) begin
            if (shd_we && coef_idx == IW'(k))
               c_shd_q[k] <= coef_val;
            if (act_we)
               c_act_q[k] <= c_shd_q[k];
         end
      end
   end

   assign coef_ack    = (state_q == S_ACK);
   assign commit_done = done_q;
   assign commit_err  = err_q;

endmodule

// File: tb/tb_tx_ffe_bdrate.sv
// tb_tx_ffe_bdrate: directed checks of tx_ffe_bdrate, one default
// instance and one with Ncode=5 for saturation and commit rejection.
module tb_tx_ffe_bdrate;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] din;

   logic signed [7:0] d0 [4];
   logic signed [4:0] d1 [4];

   logic req0, commit0, ack0, done0, err0;
   logic [1:0] idx0;
   logic signed [5:0] val0;

   logic req1, commit1, ack1, done1, err1;
   logic [1:0] idx1;
   logic signed [5:0] val1;

   int n_assert = 0;
   int n_fail   = 0;
   int cnt;

   always #5 clk = ~clk;

   tx_ffe_bdrate u0 (
      .clk(clk), .rst(rst), .din(din), .dout(d0),
      .coef_req(req0), .coef_idx(idx0), .coef_val(val0),
      .coef_ack(ack0), .coef_commit(commit0),
      .commit_done(done0), .commit_err(err0)
   );

   tx_ffe_bdrate #(.Ncode(5)) u1 (
      .clk(clk), .rst(rst), .din(din), .dout(d1),
      .coef_req(req1), .coef_idx(idx1), .coef_val(val1),
      .coef_ack(ack1), .coef_commit(commit1),
      .commit_done(done1), .commit_err(err1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic look(input bit u, input string tag,
                       input int e0, input int e1,
                       input int e2, input int e3);
      int e [4];
      e = '{e0, e1, e2, e3};
      for (int j = 0; j < 4; j++)
         if (u) chk($sformatf("%s[%0d]", tag, j), d1[j], e[j]);
         else   chk($sformatf("%s[%0d]", tag, j), d0[j], e[j]);
   endtask

   task automatic word(input bit u, input string tag, input logic [3:0] v,
                       input int e0, input int e1,
                       input int e2, input int e3);
      din = v;
      tick();
      look(u, tag, e0, e1, e2, e3);
   endtask

   task automatic write(input bit u, input logic [1:0] idx,
                        input logic signed [5:0] val);
      int k;
      if (u) begin req1 = 1'b1; idx1 = idx; val1 = val; end
      else   begin req0 = 1'b1; idx0 = idx; val0 = val; end
      k = 0;
      do begin
         tick();
         k++;
      end while (!(u ? ack1 : ack0) && k < 8);
      chk("wr_ack", u ? ack1 : ack0, 1);
      if (u) req1 = 1'b0;
      else   req0 = 1'b0;
      tick();
      tick();
   endtask

   task automatic commit(input bit u, input int e_done, input int e_err);
      if (u) commit1 = 1'b1;
      else   commit0 = 1'b1;
      tick();
      commit0 = 1'b0;
      commit1 = 1'b0;
      chk("cm_early", u ? done1 : done0, 0);
      tick();
      chk("cm_done", u ? done1 : done0, e_done);
      chk("cm_err", u ? err1 : err0, e_err);
      tick();
      chk("cm_done_off", u ? done1 : done0, 0);
      chk("cm_err_off", u ? err1 : err0, 0);
   endtask

   initial begin
      rst = 1'b1; din = 4'b0000;
      req0 = 0; commit0 = 0; idx0 = 0; val0 = 0;
      req1 = 0; commit1 = 0; idx1 = 0; val1 = 0;
      tick();
      tick();
      look(0, "rst_d0", 0, 0, 0, 0);
      look(1, "rst_d1", 0, 0, 0, 0);
      chk("rst_ack", ack0, 0);
      chk("rst_done", done0, 0);
      chk("rst_err", err0, 0);
      rst = 1'b0;

      word(0, "w1111", 4'b1111, 31, 31, 31, 31);
      look(1, "sat_pos", 15, 15, 15, 15);
      word(0, "w0000", 4'b0000, -31, -31, -31, -31);
      look(1, "sat_neg", -15, -15, -15, -15);

      write(0, 2'd0, 6'sd31);
      write(0, 2'd1, -6'sd8);
      commit(0, 1, 0);
      word(0, "p0000", 4'b0000, -23, -23, -23, -23);
      word(0, "p1011", 4'b1011, 39, 23, -39, 39);
      word(0, "p0100", 4'b0100, -39, -23, 39, -39);

      write(1, 2'd1, 6'sd31);
      commit(1, 0, 1);
      word(1, "err_keep", 4'b0101, 15, -15, 15, -15);
      write(1, 2'd0, 6'sd10);
      write(1, 2'd1, 6'sd5);
      commit(1, 1, 0);
      word(1, "lim_alt", 4'b0101, 5, -5, 5, -5);
      word(1, "lim_top", 4'b1111, 5, 15, 15, 15);
      write(1, 2'd1, 6'sd6);
      commit(1, 0, 1);
      word(1, "lim_over", 4'b0000, -5, -15, -15, -15);

      req0 = 1'b1; idx0 = 2'd2; val0 = 6'sd5;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt += int'(ack0);
      end
      chk("hold_acks", cnt, 1);
      req0 = 1'b0;
      tick();
      tick();
      req0 = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         cnt += int'(ack0);
      end
      chk("reraise_acks", cnt, 1);
      req0 = 1'b0;
      tick();
      tick();
      commit(0, 1, 0);
      word(0, "badidx", 4'b1011, 39, 23, -39, 39);

      word(0, "q0000", 4'b0000, -39, -23, -23, -23);
      req0 = 1'b1; idx0 = 2'd0; val0 = 6'sd20;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!ack0 && cnt < 8);
      chk("ack_seen", ack0, 1);
      req0 = 1'b0;
      commit0 = 1'b1;
      tick();
      commit0 = 1'b0;
      chk("ca_b", done0, 0);
      tick();
      chk("ca_c", done0, 0);
      tick();
      chk("ca_d", done0, 0);
      tick();
      chk("ca_e", done0, 1);
      tick();
      chk("ca_off", done0, 0);
      word(0, "ca_taps", 4'b1011, 28, 12, -28, 28);

      req0 = 1'b1; idx0 = 2'd1; val0 = -6'sd4;
      commit0 = 1'b1;
      tick();
      commit0 = 1'b0;
      chk("pri_noack", ack0, 0);
      tick();
      chk("pri_done", done0, 1);
      chk("pri_ack0", ack0, 0);
      tick();
      chk("pri_ack", ack0, 1);
      req0 = 1'b0;
      tick();
      tick();

      req0 = 1'b1; idx0 = 2'd0; val0 = -6'sd10;
      tick();
      chk("mr_ack", ack0, 1);
      tick();
      commit0 = 1'b1;
      tick();
      commit0 = 1'b0;
      rst = 1'b1;
      #1;
      look(0, "arst", 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      req0 = 1'b0;
      din = 4'b0000;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         cnt += int'(done0);
      end
      chk("pend_drop", cnt, 0);
      commit(0, 1, 0);
      word(0, "shd_lost", 4'b1011, 31, 31, -31, 31);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
